// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (core, loader), the shared memory port
// and the arbiter that sits in the middle.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              c_req;
   logic              c_we;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata;
   logic              c_gnt;
   logic              c_done;
   logic [DATA_W-1:0] c_rdata;

   logic              l_req;
   logic              l_we;
   logic [ADDR_W-1:0] l_addr;
   logic [DATA_W-1:0] l_wdata;
   logic              l_gnt;
   logic              l_done;
   logic [DATA_W-1:0] l_rdata;

   logic              m_req;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic              m_ready;
   logic [DATA_W-1:0] m_rdata;

   logic              err;
   logic              busy;

   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      output c_gnt, c_done, c_rdata,
      input  l_req, l_we, l_addr, l_wdata,
      output l_gnt, l_done, l_rdata,
      output m_req, m_we, m_addr, m_wdata,
      input  m_ready, m_rdata,
      output err, busy
   );

   modport master (
      output c_req, c_we, c_addr, c_wdata,
      input  c_gnt, c_done, c_rdata,
      output l_req, l_we, l_addr, l_wdata,
      input  l_gnt, l_done, l_rdata,
      input  m_req, m_we, m_addr, m_wdata,
      output m_ready, m_rdata,
      input  err, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between core and loader: one access in flight,
// alternating on ties, with an optional bounded wait on m_ready.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.slave  bus
);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic {CORE, LOADER} owner_t;

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   owner_t            last_owner_q, last_owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              m_req_q, m_req_d;
   logic              m_we_q, m_we_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
   logic              c_gnt_q, c_gnt_d;
   logic              l_gnt_q, l_gnt_d;
   logic              c_done_q, c_done_d;
   logic              l_done_q, l_done_d;
   logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
   logic [DATA_W-1:0] l_rdata_q, l_rdata_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              pick_core;

   // Core takes a lone core request, or a tie when the loader went last.
   assign pick_core = bus.c_req && (!bus.l_req || last_owner_q == LOADER);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      cnt_d        = cnt_q;
      m_req_d      = m_req_q;
      m_we_d       = m_we_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      c_gnt_d      = 1'b0;
      l_gnt_d      = 1'b0;
      c_done_d     = 1'b0;
      l_done_d     = 1'b0;
      c_rdata_d    = c_rdata_q;
      l_rdata_d    = l_rdata_q;
      err_d        = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.c_req || bus.l_req) begin
               owner_d   = pick_core ? CORE : LOADER;
               m_we_d    = pick_core ? bus.c_we    : bus.l_we;
               m_addr_d  = pick_core ? bus.c_addr  : bus.l_addr;
               m_wdata_d = pick_core ? bus.c_wdata : bus.l_wdata;
               m_req_d   = 1'b1;
               c_gnt_d   = pick_core;
               l_gnt_d   = !pick_core;
               cnt_d     = '0;
               state_d   = ACCESS;
            end
         end
         ACCESS: begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            if (bus.m_ready) begin
               if (!m_we_q) begin
                  if (owner_q == CORE) c_rdata_d = bus.m_rdata;
                  else                 l_rdata_d = bus.m_rdata;
               end
               m_req_d  = 1'b0;
               c_done_d = (owner_q == CORE);
               l_done_d = (owner_q == LOADER);
               state_d  = DONE;
            end else if (TIMEOUT > 0 && cnt_q == CNT_LAST) begin
               m_req_d  = 1'b0;
               c_done_d = (owner_q == CORE);
               l_done_d = (owner_q == LOADER);
               err_d    = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            last_owner_d = owner_q;
            cnt_d        = '0;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= CORE;
         last_owner_q <= LOADER;
         cnt_q        <= '0;
         m_req_q      <= 1'b0;
         m_we_q       <= 1'b0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         c_gnt_q      <= 1'b0;
         l_gnt_q      <= 1'b0;
         c_done_q     <= 1'b0;
         l_done_q     <= 1'b0;
         c_rdata_q    <= '0;
         l_rdata_q    <= '0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         cnt_q        <= cnt_d;
         m_req_q      <= m_req_d;
         m_we_q       <= m_we_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         c_gnt_q      <= c_gnt_d;
         l_gnt_q      <= l_gnt_d;
         c_done_q     <= c_done_d;
         l_done_q     <= l_done_d;
         c_rdata_q    <= c_rdata_d;
         l_rdata_q    <= l_rdata_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.m_req   = m_req_q;
   assign bus.m_we    = m_we_q;
   assign bus.m_addr  = m_addr_q;
   assign bus.m_wdata = m_wdata_q;
   assign bus.c_gnt   = c_gnt_q;
   assign bus.l_gnt   = l_gnt_q;
   assign bus.c_done  = c_done_q;
   assign bus.l_done  = l_done_q;
   assign bus.c_rdata = c_rdata_q;
   assign bus.l_rdata = l_rdata_q;
   assign bus.err     = err_q;
   assign bus.busy    = busy_q;
endmodule
